time_of_day_counter: RTL and testbench
======================================

// Module: time_of_day_counter
// PURPOSE
// - BCD hh:mm:ss time-of-day counter for the alarm clock; consumes the 1 Hz strobe of the
//   upstream clock divider and feeds display mux and alarm comparator downstream.
// - Supports synchronous time load (set mode), per-field increment buttons, 24h/12h modes.
// - All outputs registered; one clock domain, no internal clock gating.
// PARAMETERS
// - MODE_24H       1  1: hours 00..23; 0: hours 12,01..11 with pm_out
// - TICKS_PER_SEC  1  strobes consumed per second (>=1); >1 lets fast divider drive sim
// PORTS
// - clk_in           in   1   system clock
// - reset_n          in   1   synchronous reset, active-low
// - tick_in          in   1   1-cycle strobe from clock divider
// - load_in          in   1   1-cycle load request for time_in
// - time_in          in   24  {hh,mm,ss} BCD, 2 nibbles each; hh in 24h format always
// - inc_min_in       in   1   1-cycle pulse: +1 minute, no carry into hours
// - inc_hour_in      in   1   1-cycle pulse: +1 hour, no carry
// - time_out         out  24  {hh,mm,ss} BCD; hh in 12h form when MODE_24H=0
// - pm_out           out  1   12h mode: 1 for 12:00..23:59 internal; 0 always in 24h mode
// - minute_strobe_out out 1   1 cycle when ss wraps 59->00 due to tick
// - day_strobe_out   out  1   1 cycle when time wraps 23:59:59->00:00:00 due to tick
// - load_err_out     out  1   1 cycle when a load_in carried an invalid time_in
// BEHAVIOUR
// - Internal time always 24h BCD; 12h conversion is output mapping only (00->12 AM, 13->01 PM).
// - reset_n=0 at a clk_in edge: internal time 00:00:00, prescaler 0, all strobes/err 0,
//   time_out = 000000 (24h) or 12:00:00 with pm_out=0 (12h). Reset wins over all inputs.
// - Prescaler: counts tick_in 0..TICKS_PER_SEC-1; "second event" on tick_in when count is
//   TICKS_PER_SEC-1, then count returns to 0. TICKS_PER_SEC=1: every tick_in is a second event.
// - Second event at edge N -> time_out updated, strobes valid, after edge N (1-cycle latency).
// - Carry chain: ss 59->00 carries mm; mm 59->00 carries hh; hh 23->00 asserts day_strobe_out.
//   Each BCD field: units 9->0 carries tens; field max 59 / 23 detected on BCD value, not binary.
// - Load: load_in=1 validates time_in: every nibble <=9, hh<=23, mm<=59, ss<=59.
//   Valid -> time := time_in, prescaler := 0, no strobes. Invalid -> time unchanged,
//   load_err_out pulses 1 cycle.
// - inc_min_in: mm := (mm+1) mod 60, ss := 00, prescaler := 0, no strobes, hh untouched.
// - inc_hour_in: hh := (hh+1) mod 24, mm/ss untouched, no strobes.
// - Priority, same cycle: reset_n > load_in > inc_hour_in > inc_min_in > tick_in.
//   Lower-priority events in a cycle with a higher one are dropped, not deferred;
//   a dropped tick_in does not advance prescaler.
//   Exception: inc_hour_in with inc_min_in applies both (hour and minute bumped, ss := 00).
// - Strobes never assert outside a second event; never two consecutive cycles from one event.
// STRUCTURE
// - Shared package clock_pkg: typedef bcd_digit_t (4b), bcd_field_t (2 digits),
//   struct time_bcd_t {hh,mm,ss}; constants SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MAX=8'h23;
//   function bcd_valid(field,max).
// - Sub-module bcd_field_counter #(MAX): one 2-digit BCD field with inc, load, carry_out at
//   MAX->00; instantiated 3x (ss, mm, hh). Prescaler, priority, 12h mapping in top.
// TESTING
// - Reset: reset_n=0 mid-count at 12:34:56 -> next cycle time_out=000000, all strobes 0.
// - Roll: load 23:59:58, 2 tick_in -> 23:59:59, then 00:00:00 with minute+day strobes 1 cycle.
// - Load check: time_in=24:00:00 or 12:5A:00 -> load_err_out 1 cycle, time unchanged;
//   09:05:07 -> loaded.
// - Collision: load 10:00:00 with tick_in same cycle -> 10:00:00, tick dropped;
//   inc_min_in at 10:59:30 -> 10:00:00.
// - Prescale: TICKS_PER_SEC=4, 8 tick_in -> ss advances by exactly 2; load resets phase.
// - 12h: MODE_24H=0, load 00:30:00 -> 12:30:00 pm_out=0;
//   load 13:05:00 -> 01:05:00 pm_out=1.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and helpers for the BCD time-of-day datapath.
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;
  // [1] tens digit, [0] units digit
  typedef logic [1:0][3:0] bcd_field_t;

  typedef struct packed {
    bcd_field_t hh;
    bcd_field_t mm;
    bcd_field_t ss;
  } time_bcd_t;

  localparam bcd_field_t SEC_MAX  = 8'h59;
  localparam bcd_field_t MIN_MAX  = 8'h59;
  localparam bcd_field_t HOUR_MAX = 8'h23;

  // Both digits decimal and the field no larger than max. Once both digits are
  // decimal, a plain vector compare orders BCD values correctly.
  function automatic logic bcd_valid(input bcd_field_t field, input bcd_field_t max);
    return (field[1] <= 4'd9) && (field[0] <= 4'd9) && (field <= max);
  endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// One two-digit BCD field that wraps from MAX to 00. Load beats increment.
// carry_out flags an increment that wraps this cycle. next_out exposes the
// next-state value so the parent can register its outputs without extra latency.
module bcd_field_counter
  import clock_pkg::*;
#(
  parameter bcd_field_t MAX = SEC_MAX
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       inc_in,
  input  logic       load_in,
  input  bcd_field_t load_val_in,
  output bcd_field_t next_out,
  output logic       carry_out
);

  bcd_field_t r_field;
  bcd_field_t w_field_inc;
  bcd_field_t w_field_d;

  // BCD increment with the wrap detected on the BCD value, then load/inc select.
  always_comb begin
    w_field_inc = r_field;
    if (r_field == MAX) begin
      w_field_inc = '0;
    end else if (r_field[0] == 4'd9) begin
      w_field_inc[1] = r_field[1] + 4'd1;
      w_field_inc[0] = 4'd0;
    end else begin
      w_field_inc[0] = r_field[0] + 4'd1;
    end

    w_field_d = r_field;
    if (load_in) begin
      w_field_d = load_val_in;
    end else if (inc_in) begin
      w_field_d = w_field_inc;
    end
  end

  // Field register with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_field <= '0;
    end else begin
      r_field <= w_field_d;
    end
  end

  assign next_out  = w_field_d;
  assign carry_out = inc_in && !load_in && (r_field == MAX);

endmodule

// File: rtl/time_of_day_counter.sv
// BCD hh:mm:ss time-of-day counter. Internal time is always 24h; the 12h view
// is only an output mapping. Prescaler, event priority and output mapping
// live here; the three fields are bcd_field_counter instances.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter bit          MODE_24H      = 1'b1,
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        tick_in,
  input  logic        load_in,
  input  logic [23:0] time_in,
  input  logic        inc_min_in,
  input  logic        inc_hour_in,
  output logic [23:0] time_out,
  output logic        pm_out,
  output logic        minute_strobe_out,
  output logic        day_strobe_out,
  output logic        load_err_out
);

  localparam int unsigned PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

  // 24h BCD hour to 12h BCD hour: 00->12, 13..19 -> 01..07, 20/21 -> 08/09,
  // 22/23 -> 10/11. Subtracting 0x12 is exact except across the tens boundary.
  function automatic bcd_field_t hh_to_12h(input bcd_field_t hh);
    bcd_field_t res;
    res = hh;
    if (hh == 8'h00) begin
      res = 8'h12;
    end else if ((hh == 8'h20) || (hh == 8'h21)) begin
      res = hh - 8'h18;
    end else if (hh > 8'h12) begin
      res = hh - 8'h12;
    end
    return res;
  endfunction

  logic [PRESC_W-1:0] r_presc;
  logic [23:0]        r_time_out;
  logic               r_pm;
  logic               r_min_strobe;
  logic               r_day_strobe;
  logic               r_load_err;

  time_bcd_t  w_time_in;
  logic       w_load_ok;
  logic       w_do_load;
  logic       w_do_inc;
  logic       w_do_tick;
  logic       w_sec_event;
  logic       w_min_bump;
  logic       w_ss_carry;
  logic       w_mm_carry;
  logic       w_hh_carry;
  bcd_field_t w_ss_d;
  bcd_field_t w_mm_d;
  bcd_field_t w_hh_d;

  assign w_time_in = time_in;
  assign w_load_ok = bcd_valid(w_time_in.hh, HOUR_MAX) &&
                     bcd_valid(w_time_in.mm, MIN_MAX) &&
                     bcd_valid(w_time_in.ss, SEC_MAX);

  // Priority: load > buttons > tick. An invalid load still swallows the cycle.
  assign w_do_load   = load_in && w_load_ok;
  assign w_do_inc    = !load_in && (inc_hour_in || inc_min_in);
  assign w_do_tick   = !load_in && !inc_hour_in && !inc_min_in && tick_in;
  assign w_sec_event = w_do_tick && (r_presc == PRESC_LAST);
  assign w_min_bump  = w_do_inc && inc_min_in;

  bcd_field_counter #(.MAX(SEC_MAX)) u_ss (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .inc_in      (w_sec_event),
    .load_in     (w_do_load || w_min_bump),
    .load_val_in (w_do_load ? w_time_in.ss : bcd_field_t'(8'h00)),
    .next_out    (w_ss_d),
    .carry_out   (w_ss_carry)
  );

  // Button increments never carry: mm_carry and hh_carry only feed the tick path.
  bcd_field_counter #(.MAX(MIN_MAX)) u_mm (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .inc_in      ((w_sec_event && w_ss_carry) || w_min_bump),
    .load_in     (w_do_load),
    .load_val_in (w_time_in.mm),
    .next_out    (w_mm_d),
    .carry_out   (w_mm_carry)
  );

  bcd_field_counter #(.MAX(HOUR_MAX)) u_hh (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .inc_in      ((w_sec_event && w_ss_carry && w_mm_carry) || (w_do_inc && inc_hour_in)),
    .load_in     (w_do_load),
    .load_val_in (w_time_in.hh),
    .next_out    (w_hh_d),
    .carry_out   (w_hh_carry)
  );

  // Tick prescaler; realigned by a valid load or a minute button press.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (w_do_load || w_min_bump) begin
      r_presc <= '0;
    end else if (w_do_tick) begin
      if (r_presc == PRESC_LAST) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PRESC_W'(1);
      end
    end
  end

  // Registered outputs: mapped time, pm flag, strobes and load error pulse.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_time_out   <= MODE_24H ? 24'h000000 : 24'h120000;
      r_pm         <= 1'b0;
      r_min_strobe <= 1'b0;
      r_day_strobe <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_time_out   <= {(MODE_24H ? w_hh_d : hh_to_12h(w_hh_d)), w_mm_d, w_ss_d};
      r_pm         <= !MODE_24H && (w_hh_d >= 8'h12);
      r_min_strobe <= w_sec_event && w_ss_carry;
      r_day_strobe <= w_sec_event && w_ss_carry && w_mm_carry && w_hh_carry;
      r_load_err   <= load_in && !w_load_ok;
    end
  end

  assign time_out          = r_time_out;
  assign pm_out            = r_pm;
  assign minute_strobe_out = r_min_strobe;
  assign day_strobe_out    = r_day_strobe;
  assign load_err_out      = r_load_err;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Self-checking bench: three counters (24h/1 tick, 24h/4 ticks, 12h/1 tick)
// share one stimulus stream; each row names which instance it checks.
module tb_time_of_day_counter;

  typedef struct packed {
    logic [23:0] t;
    logic        pm;
    logic        ms;
    logic        ds;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        rst;
    logic        tick;
    logic        ld;
    logic        ih;
    logic        im;
    logic [23:0] tv;
    logic [1:0]  id;
    exp_t        e;
  } row_t;

  logic        clk_in = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick_in = 1'b0;
  logic        load_in = 1'b0;
  logic [23:0] time_in = '0;
  logic        inc_min_in = 1'b0;
  logic        inc_hour_in = 1'b0;

  logic [23:0] t_a, t_b, t_c;
  logic        pm_a, pm_b, pm_c, ms_a, ms_b, ms_c, ds_a, ds_b, ds_c, er_a, er_b, er_c;

  exp_t exp_q[$];
  int   id_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk_in = ~clk_in;

  time_of_day_counter #(.MODE_24H(1'b1), .TICKS_PER_SEC(1)) dut_a (
    .clk_in (clk_in), .reset_n (reset_n), .tick_in (tick_in), .load_in (load_in),
    .time_in (time_in), .inc_min_in (inc_min_in), .inc_hour_in (inc_hour_in),
    .time_out (t_a), .pm_out (pm_a), .minute_strobe_out (ms_a), .day_strobe_out (ds_a),
    .load_err_out (er_a)
  );

  time_of_day_counter #(.MODE_24H(1'b1), .TICKS_PER_SEC(4)) dut_b (
    .clk_in (clk_in), .reset_n (reset_n), .tick_in (tick_in), .load_in (load_in),
    .time_in (time_in), .inc_min_in (inc_min_in), .inc_hour_in (inc_hour_in),
    .time_out (t_b), .pm_out (pm_b), .minute_strobe_out (ms_b), .day_strobe_out (ds_b),
    .load_err_out (er_b)
  );

  time_of_day_counter #(.MODE_24H(1'b0), .TICKS_PER_SEC(1)) dut_c (
    .clk_in (clk_in), .reset_n (reset_n), .tick_in (tick_in), .load_in (load_in),
    .time_in (time_in), .inc_min_in (inc_min_in), .inc_hour_in (inc_hour_in),
    .time_out (t_c), .pm_out (pm_c), .minute_strobe_out (ms_c), .day_strobe_out (ds_c),
    .load_err_out (er_c)
  );

  function automatic exp_t observe(input int id);
    exp_t o;
    case (id)
      0:       o = '{t: t_a, pm: pm_a, ms: ms_a, ds: ds_a, err: er_a};
      1:       o = '{t: t_b, pm: pm_b, ms: ms_b, ds: ds_b, err: er_b};
      default: o = '{t: t_c, pm: pm_c, ms: ms_c, ds: ds_c, err: er_c};
    endcase
    return o;
  endfunction

  function automatic row_t mk(input int id, input logic tk, ld, ih, im, input logic [23:0] tv,
                              input logic [23:0] t, input logic pm, ms, ds, err);
    row_t r;
    r.rst  = 1'b0;
    r.tick = tk;
    r.ld   = ld;
    r.ih   = ih;
    r.im   = im;
    r.tv   = tv;
    r.id   = 2'(id);
    r.e    = '{t: t, pm: pm, ms: ms, ds: ds, err: err};
    return r;
  endfunction

  task automatic drive(input row_t r);
    reset_n     = !r.rst;
    tick_in     = r.tick;
    load_in     = r.ld;
    inc_hour_in = r.ih;
    inc_min_in  = r.im;
    time_in     = r.tv;
  endtask

  task automatic test_reset();
    row_t rows[$];
    row_t r;
    exp_t e, o;
    int   id;
    r = mk(0, 0, 0, 0, 0, 24'h0, 24'h000000, 0, 0, 0, 0); r.rst = 1'b1; rows.push_back(r);
    r = mk(1, 0, 0, 0, 0, 24'h0, 24'h000000, 0, 0, 0, 0); r.rst = 1'b1; rows.push_back(r);
    r = mk(2, 0, 0, 0, 0, 24'h0, 24'h120000, 0, 0, 0, 0); r.rst = 1'b1; rows.push_back(r);
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h123456, 24'h123456, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 0, 0, 0, 24'h0, 24'h123457, 0, 0, 0, 0));
    // Reset must beat a simultaneous load and tick.
    r = mk(0, 1, 1, 0, 0, 24'h235958, 24'h000000, 0, 0, 0, 0); r.rst = 1'b1; rows.push_back(r);
    rows.push_back(mk(0, 0, 0, 0, 0, 24'h0, 24'h000000, 0, 0, 0, 0));
    rows.push_back(mk(2, 0, 1, 0, 0, 24'h153000, 24'h033000, 1, 0, 0, 0));
    r = mk(2, 1, 1, 0, 0, 24'h100000, 24'h120000, 0, 0, 0, 0); r.rst = 1'b1; rows.push_back(r);
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].e);
      id_q.push_back(int'(rows[i].id));
      @(posedge clk_in); #1;
      e = exp_q.pop_front(); id = id_q.pop_front(); o = observe(id);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset[%0d] dut%0d got %h/%b%b%b%b want %h/%b%b%b%b", i, id,
                 o.t, o.pm, o.ms, o.ds, o.err, e.t, e.pm, e.ms, e.ds, e.err);
      end
    end
  endtask

  task automatic test_load_check();
    row_t rows[$];
    exp_t e, o;
    int   id;
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h090507, 24'h090507, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h240000, 24'h090507, 0, 0, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 24'h0,      24'h090507, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h125A00, 24'h090507, 0, 0, 0, 1));
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h12345A, 24'h090507, 0, 0, 0, 1));
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h123460, 24'h090507, 0, 0, 0, 1));
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h235959, 24'h235959, 0, 0, 0, 0));
    // Invalid load still drops a same-cycle tick.
    rows.push_back(mk(0, 1, 1, 0, 0, 24'h0A0000, 24'h235959, 0, 0, 0, 1));
    rows.push_back(mk(0, 1, 0, 0, 0, 24'h0,      24'h000000, 0, 1, 1, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].e);
      id_q.push_back(int'(rows[i].id));
      @(posedge clk_in); #1;
      e = exp_q.pop_front(); id = id_q.pop_front(); o = observe(id);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL load_check[%0d] dut%0d got %h/%b%b%b%b want %h/%b%b%b%b", i, id,
                 o.t, o.pm, o.ms, o.ds, o.err, e.t, e.pm, e.ms, e.ds, e.err);
      end
    end
  endtask

  task automatic test_roll();
    row_t rows[$];
    exp_t e, o;
    int   id;
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h235958, 24'h235958, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 0, 0, 0, 24'h0,      24'h235959, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 0, 0, 0, 24'h0,      24'h000000, 0, 1, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 24'h0,      24'h000000, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h102059, 24'h102059, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 0, 0, 0, 24'h0,      24'h102100, 0, 1, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h095959, 24'h095959, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 0, 0, 0, 24'h0,      24'h100000, 0, 1, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h195959, 24'h195959, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 0, 0, 0, 24'h0,      24'h200000, 0, 1, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].e);
      id_q.push_back(int'(rows[i].id));
      @(posedge clk_in); #1;
      e = exp_q.pop_front(); id = id_q.pop_front(); o = observe(id);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL roll[%0d] dut%0d got %h/%b%b%b%b want %h/%b%b%b%b", i, id,
                 o.t, o.pm, o.ms, o.ds, o.err, e.t, e.pm, e.ms, e.ds, e.err);
      end
    end
  endtask

  task automatic test_collision();
    row_t rows[$];
    exp_t e, o;
    int   id;
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h090000, 24'h090000, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 1, 0, 0, 24'h100000, 24'h100000, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 24'h0,      24'h100000, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h105930, 24'h105930, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 1, 24'h0,      24'h100000, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h105930, 24'h105930, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 0, 0, 1, 24'h0,      24'h100000, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h235910, 24'h235910, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 1, 0, 24'h0,      24'h005910, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h235910, 24'h235910, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 1, 1, 24'h0,      24'h000000, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h115959, 24'h115959, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 0, 1, 0, 24'h0,      24'h125959, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 1, 1, 24'h100000, 24'h100000, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h095959, 24'h095959, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 1, 24'h0,      24'h090000, 0, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].e);
      id_q.push_back(int'(rows[i].id));
      @(posedge clk_in); #1;
      e = exp_q.pop_front(); id = id_q.pop_front(); o = observe(id);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL collision[%0d] dut%0d got %h/%b%b%b%b want %h/%b%b%b%b", i, id,
                 o.t, o.pm, o.ms, o.ds, o.err, e.t, e.pm, e.ms, e.ds, e.err);
      end
    end
  endtask

  task automatic test_prescale();
    row_t rows[$];
    exp_t e, o;
    int   id;
    rows.push_back(mk(1, 0, 1, 0, 0, 24'h000000, 24'h000000, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 24'h0,      24'h000000, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 24'h0,      24'h000000, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 24'h0,      24'h000000, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 24'h0,      24'h000000, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 24'h0,      24'h000001, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 24'h0,      24'h000001, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 24'h0,      24'h000001, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 24'h0,      24'h000001, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 24'h0,      24'h000002, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 24'h0,      24'h000002, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 24'h0,      24'h000002, 0, 0, 0, 0));
    // Load with the prescaler at phase 2 restarts the count from zero.
    rows.push_back(mk(1, 0, 1, 0, 0, 24'h000010, 24'h000010, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 24'h0,      24'h000010, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 24'h0,      24'h000010, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 24'h0,      24'h000010, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 0, 0, 0, 24'h0,      24'h000011, 0, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].e);
      id_q.push_back(int'(rows[i].id));
      @(posedge clk_in); #1;
      e = exp_q.pop_front(); id = id_q.pop_front(); o = observe(id);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL prescale[%0d] dut%0d got %h/%b%b%b%b want %h/%b%b%b%b", i, id,
                 o.t, o.pm, o.ms, o.ds, o.err, e.t, e.pm, e.ms, e.ds, e.err);
      end
    end
  endtask

  task automatic test_12h();
    row_t rows[$];
    exp_t e, o;
    int   id;
    rows.push_back(mk(2, 0, 1, 0, 0, 24'h003000, 24'h123000, 0, 0, 0, 0));
    rows.push_back(mk(2, 0, 1, 0, 0, 24'h130500, 24'h010500, 1, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h130500, 24'h130500, 0, 0, 0, 0));
    rows.push_back(mk(2, 0, 1, 0, 0, 24'h120000, 24'h120000, 1, 0, 0, 0));
    rows.push_back(mk(2, 0, 1, 0, 0, 24'h110000, 24'h110000, 0, 0, 0, 0));
    rows.push_back(mk(2, 0, 1, 0, 0, 24'h205000, 24'h085000, 1, 0, 0, 0));
    rows.push_back(mk(2, 0, 1, 0, 0, 24'h220000, 24'h100000, 1, 0, 0, 0));
    rows.push_back(mk(2, 0, 1, 0, 0, 24'h235958, 24'h115958, 1, 0, 0, 0));
    rows.push_back(mk(2, 1, 0, 0, 0, 24'h0,      24'h115959, 1, 0, 0, 0));
    rows.push_back(mk(2, 1, 0, 0, 0, 24'h0,      24'h120000, 0, 1, 1, 0));
    rows.push_back(mk(2, 0, 1, 0, 0, 24'h115959, 24'h115959, 0, 0, 0, 0));
    rows.push_back(mk(2, 1, 0, 0, 0, 24'h0,      24'h120000, 1, 1, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].e);
      id_q.push_back(int'(rows[i].id));
      @(posedge clk_in); #1;
      e = exp_q.pop_front(); id = id_q.pop_front(); o = observe(id);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL mode12h[%0d] dut%0d got %h/%b%b%b%b want %h/%b%b%b%b", i, id,
                 o.t, o.pm, o.ms, o.ds, o.err, e.t, e.pm, e.ms, e.ds, e.err);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    exp_t e, o;
    int   id;
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h000058, 24'h000058, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 0, 0, 0, 24'h0,      24'h000059, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 0, 0, 0, 24'h0,      24'h000100, 0, 1, 0, 0));
    rows.push_back(mk(0, 1, 0, 0, 0, 24'h0,      24'h000101, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 24'h0,      24'h000101, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h2A0000, 24'h000101, 0, 0, 0, 1));
    rows.push_back(mk(0, 0, 1, 0, 0, 24'h2A0000, 24'h000101, 0, 0, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 24'h0,      24'h000101, 0, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].e);
      id_q.push_back(int'(rows[i].id));
      @(posedge clk_in); #1;
      e = exp_q.pop_front(); id = id_q.pop_front(); o = observe(id);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d] dut%0d got %h/%b%b%b%b want %h/%b%b%b%b", i, id,
                 o.t, o.pm, o.ms, o.ds, o.err, e.t, e.pm, e.ms, e.ds, e.err);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_check();
    test_roll();
    test_collision();
    test_prescale();
    test_12h();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
